// File: rtl/ram_pkg.sv
// Shared types, read-during-write mode constants and the byte-merge helper for ram_dp_param.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ram_state_e;

  localparam int unsigned RDW_OLD      = 0;
  localparam int unsigned RDW_NEW_DATA = 1;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int unsigned MAX_DW = 1024;
  localparam int unsigned MAX_BE = MAX_DW / 8;

  function automatic logic [MAX_DW-1:0] be_merge(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_BE-1:0] be
  );
    logic [MAX_DW-1:0] merged;
    merged = old_w;
    for (int i = 0; i < int'(MAX_BE); i++) begin
      if (be[i]) merged[8*i +: 8] = new_w[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_init_seq.sv
// Post-reset clear sequencer: walks every address writing zero, then enters RUN.
// Only instantiated when RAM_DP_CLEAR_EN is defined.
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int unsigned ADDRESSES = 1024,
  parameter int unsigned AW        = $clog2(ADDRESSES)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          ready,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(ADDRESSES - 1);

  ram_state_e    r_state;
  ram_state_e    w_state_nxt;
  logic [AW-1:0] r_clr_addr;
  logic [AW-1:0] w_clr_addr_nxt;
  logic          r_ready;
  logic          r_clr_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
      r_ready    <= 1'b0;
      r_clr_we   <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
      r_ready    <= (w_state_nxt == RUN);
      r_clr_we   <= (w_state_nxt == CLEAR);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    case (r_state)
      CLEAR: begin
        if (r_clr_addr == LAST_ADDR) begin
          w_state_nxt    = RUN;
          w_clr_addr_nxt = '0;
        end else begin
          w_clr_addr_nxt = r_clr_addr + AW'(1);
        end
      end
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = CLEAR;
    endcase
  end

  assign ready    = r_ready;
  assign clr_we   = r_clr_we;
  assign clr_addr = r_clr_addr;

endmodule

// File: rtl/ram_dp_param.sv
// Simple-dual-port RAM with byte enables, 1- or 2-cycle read latency and selectable read-during-write.
// Define RAM_DP_CLEAR_EN to zero the array after reset before raising ready.
module ram_dp_param
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDRESSES  = 1024,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned RDW_NEW    = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic                          ready,
  input  logic                          wr_en,
  input  logic [$clog2(ADDRESSES)-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic [DATA_WIDTH/8-1:0]       wr_be,
  input  logic                          rd_en,
  input  logic [$clog2(ADDRESSES)-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid
);

  localparam int unsigned AW  = $clog2(ADDRESSES);
  localparam int unsigned AWP = AW + 1;
  localparam int unsigned NB  = DATA_WIDTH / 8;
  localparam logic [AW:0] ADDR_LIM = AWP'(ADDRESSES);

  logic          w_ready;
  logic          w_clr_we;
  logic [AW-1:0] w_clr_addr;

`ifdef RAM_DP_CLEAR_EN
  ram_init_seq #(
    .ADDRESSES (ADDRESSES),
    .AW        (AW)
  ) u_init_seq (
    .clk      (clk),
    .reset    (reset),
    .ready    (w_ready),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );
`else
  logic r_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_ready <= 1'b0;
    else       r_ready <= 1'b1;
  end

  assign w_ready    = r_ready;
  assign w_clr_we   = 1'b0;
  assign w_clr_addr = '0;
`endif

  assign ready = w_ready;

  logic w_wr_inr;
  logic w_rd_inr;
  logic w_wr_go;
  logic w_rd_go;
  logic w_collide;

  assign w_wr_inr  = ({1'b0, wr_addr} < ADDR_LIM);
  assign w_rd_inr  = ({1'b0, rd_addr} < ADDR_LIM);
  assign w_wr_go   = w_ready & wr_en & w_wr_inr;
  assign w_rd_go   = w_ready & rd_en;
  assign w_collide = w_wr_go & (wr_addr == rd_addr);

  // Clear sequencer owns the write port until ready.
  logic                  w_we;
  logic [AW-1:0]         w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [NB-1:0]         w_wbe;

  always_comb begin
    w_we    = w_wr_go;
    w_waddr = wr_addr;
    w_wdata = wr_data;
    w_wbe   = wr_be;
    if (w_clr_we) begin
      w_we    = 1'b1;
      w_waddr = w_clr_addr;
      w_wdata = '0;
      w_wbe   = '1;
    end
  end

  logic [DATA_WIDTH-1:0] r_mem [ADDRESSES];

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (w_wbe[b]) r_mem[w_waddr][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // Out-of-range reads return zero; collisions optionally forward the written bytes.
  logic [DATA_WIDTH-1:0] w_rd_word;

  always_comb begin
    w_rd_word = '0;
    if (w_rd_inr) begin
      w_rd_word = r_mem[rd_addr];
      if ((RDW_NEW == RDW_NEW_DATA) && w_collide) begin
        w_rd_word = DATA_WIDTH'(be_merge(MAX_DW'(w_rd_word), MAX_DW'(wr_data), MAX_BE'(wr_be)));
      end
    end
  end

  logic                  r_v1;
  logic [DATA_WIDTH-1:0] r_d1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1 <= 1'b0;
      r_d1 <= '0;
    end else begin
      r_v1 <= w_rd_go;
      if (w_rd_go) r_d1 <= w_rd_word;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic                  r_v2;
      logic [DATA_WIDTH-1:0] r_d2;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_v2 <= 1'b0;
          r_d2 <= '0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) r_d2 <= r_d1;
        end
      end

      assign rd_valid = r_v2;
      assign rd_data  = r_d2;
    end else begin : g_lat1
      assign rd_valid = r_v1;
      assign rd_data  = r_d1;
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp_param.sv
// Bench for ram_dp_param: two instances (latency 1 / old-data, latency 2 / new-data) share stimulus
// and are checked every cycle against an array-and-queue model, plus hand-computed literals.
module tb_ram_dp_param;

  localparam int unsigned NADDR = 12;
`ifdef RAM_DP_CLEAR_EN
  localparam int N_RDY = NADDR;
`else
  localparam int N_RDY = 1;
`endif

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic        ready_a, ready_b;
  logic [15:0] a_data, b_data;
  logic        a_valid, b_valid;

  int n_chk;
  int n_fail;
  logic chk_en;

  ram_dp_param #(.DATA_WIDTH(16), .ADDRESSES(NADDR), .RD_LAT(1), .RDW_NEW(0)) dut_a (
    .clk(clk), .reset(reset), .ready(ready_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_data), .rd_valid(a_valid)
  );

  ram_dp_param #(.DATA_WIDTH(16), .ADDRESSES(NADDR), .RD_LAT(2), .RDW_NEW(1)) dut_b (
    .clk(clk), .reset(reset), .ready(ready_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_data), .rd_valid(b_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: memory array, edge counter for ready, and per-instance queues of due results.
  typedef struct {
    int unsigned due;
    logic [15:0] d;
  } pend_t;

  logic [15:0] m_mem [NADDR];
  int unsigned m_edges;
  logic        m_ready;
  pend_t       qa[$];
  pend_t       qb[$];
  logic        ea_v, eb_v;
  logic [15:0] ea_d, eb_d;

  always @(posedge clk or posedge reset) begin : mdl
    logic [15:0] r_old;
    logic [15:0] r_new;
    if (reset) begin
      m_edges = 0;
      m_ready = 1'b0;
      qa.delete();
      qb.delete();
      ea_v = 1'b0; eb_v = 1'b0;
      ea_d = 16'h0; eb_d = 16'h0;
      for (int i = 0; i < int'(NADDR); i++) begin
`ifdef RAM_DP_CLEAR_EN
        m_mem[i] = 16'h0000;
`else
        m_mem[i] = 16'hxxxx;
`endif
      end
    end else begin
      m_edges++;
      if (m_ready && rd_en) begin
        r_old = 16'h0;
        r_new = 16'h0;
        if (rd_addr < 4'(NADDR)) begin
          r_old = m_mem[rd_addr];
          r_new = r_old;
          if (wr_en && wr_addr == rd_addr) begin
            if (wr_be[0]) r_new[7:0]  = wr_data[7:0];
            if (wr_be[1]) r_new[15:8] = wr_data[15:8];
          end
        end
        qa.push_back('{m_edges, r_old});
        qb.push_back('{m_edges + 1, r_new});
      end
      if (m_ready && wr_en && wr_addr < 4'(NADDR)) begin
        if (wr_be[0]) m_mem[wr_addr][7:0]  = wr_data[7:0];
        if (wr_be[1]) m_mem[wr_addr][15:8] = wr_data[15:8];
      end
      ea_v = 1'b0;
      if (qa.size() > 0 && qa[0].due == m_edges) begin
        ea_v = 1'b1;
        ea_d = qa[0].d;
        void'(qa.pop_front());
      end
      eb_v = 1'b0;
      if (qb.size() > 0 && qb[0].due == m_edges) begin
        eb_v = 1'b1;
        eb_d = qb[0].d;
        void'(qb.pop_front());
      end
      m_ready = (m_edges >= N_RDY);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready_a", 16'(ready_a), 16'(m_ready));
      chk("ready_b", 16'(ready_b), 16'(m_ready));
      chk("valid_a", 16'(a_valid), 16'(ea_v));
      chk("valid_b", 16'(b_valid), 16'(eb_v));
      chk("data_a", a_data, ea_d);
      chk("data_b", b_data, eb_d);
    end
  end

  task automatic cyc(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                     input logic [1:0] wbe, input logic re, input logic [3:0] ra);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = wbe; rd_en = re; rd_addr = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);
  endtask

  // Releases reset with both strobes active (they must be ignored) and counts edges to ready.
  task automatic release_and_wait(output int n);
    reset = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hFFFF; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 4'd2;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ready_a && n < 200);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic init_mem();
`ifndef RAM_DP_CLEAR_EN
    for (int i = 0; i < int'(NADDR); i++) cyc(1'b1, 4'(i), 16'h0000, 2'b11, 1'b0, 4'd0);
`endif
    idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    n_chk = 0; n_fail = 0; chk_en = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0; rd_en = 1'b0; rd_addr = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 16'(ready_a), 16'h0);
    chk("rst_valid", 16'(b_valid), 16'h0);
    chk("rst_data", a_data, 16'h0);

    release_and_wait(n);
    chk("ready_edges", 16'(n), 16'(N_RDY));
    init_mem();

    for (int i = 0; i < int'(NADDR); i++) cyc(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(i));
    idle(); idle();

    // Byte enables
    cyc(1'b1, 4'd5, 16'hABCD, 2'b11, 1'b0, 4'd0);
    cyc(1'b1, 4'd5, 16'h1234, 2'b01, 1'b0, 4'd0);
    cyc(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd5);
    chk("be_a_valid", 16'(a_valid), 16'h1);
    chk("be_a_data", a_data, 16'hAB34);
    chk("be_b_early", 16'(b_valid), 16'h0);
    idle();
    chk("be_b_valid", 16'(b_valid), 16'h1);
    chk("be_b_data", b_data, 16'hAB34);
    chk("be_a_hold", a_data, 16'hAB34);

    // Collision
    cyc(1'b1, 4'd3, 16'h1111, 2'b11, 1'b0, 4'd0);
    cyc(1'b1, 4'd3, 16'h2222, 2'b10, 1'b1, 4'd3);
    chk("col_old", a_data, 16'h1111);
    idle();
    chk("col_new", b_data, 16'h2211);
    cyc(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3);
    chk("col_after", a_data, 16'h2211);
    idle(); idle();

    // Back-to-back reads at latency 2
    for (int i = 0; i < 8; i++) cyc(1'b1, 4'(i), 16'(32'hA000 + i), 2'b11, 1'b0, 4'd0);
    for (int s = 0; s < 10; s++) begin
      if (s < 8) cyc(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(s));
      else       idle();
      chk("b2b_valid", 16'(b_valid), 16'((s >= 1 && s <= 8) ? 1 : 0));
      if (s >= 1 && s <= 8) chk("b2b_data", b_data, 16'(32'hA000 + s - 1));
    end

    // Write-then-read visibility, no forwarding of a later write, byte-enable-zero no-op
    cyc(1'b1, 4'd9, 16'hBEEF, 2'b11, 1'b0, 4'd0);
    cyc(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd9);
    chk("wr_vis", a_data, 16'hBEEF);
    cyc(1'b1, 4'd9, 16'h0000, 2'b11, 1'b0, 4'd0);
    chk("no_fwd", b_data, 16'hBEEF);
    cyc(1'b1, 4'd9, 16'hFFFF, 2'b00, 1'b0, 4'd0);
    cyc(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd9);
    chk("be0_noop", a_data, 16'h0000);
    idle(); idle();

    // Out-of-range
    cyc(1'b1, 4'd13, 16'h5A5A, 2'b11, 1'b0, 4'd0);
    cyc(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd13);
    chk("oor_valid", 16'(a_valid), 16'h1);
    chk("oor_data", a_data, 16'h0000);
    for (int i = 0; i < 16; i++) cyc(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(i));
    idle(); idle();

    // Reset mid-read
    cyc(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd5);
    rd_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_ready", 16'(ready_a), 16'h0);
    chk("mid_data_b", b_data, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_valid_b", 16'(b_valid), 16'h0);
    chk("mid_data_a", a_data, 16'h0);
    release_and_wait(n);
    chk("ready_edges2", 16'(n), 16'(N_RDY));
    init_mem();
    cyc(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd5);
    chk("post_rst_valid", 16'(a_valid), 16'h1);
    chk("post_rst_data", a_data, 16'h0000);
    idle(); idle();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
